// File: rtl/uart_fifo_bridge_if.sv
// Simple single-cycle register bus used on both the host side and the
// UART side of the FIFO bridge.
interface uart_fifo_bridge_if;
    logic [3:0]  address;
    logic        read;
    logic [31:0] readData;
    logic        write;
    logic [31:0] writeData;
    logic        waitrequest;

    modport master (
        output address, read, write, writeData,
        input  readData
    );

    modport slave (
        input  address, read, write, writeData,
        output readData, waitrequest
    );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Buffered TX/RX FIFOs in front of a FIFO-less UART register slave,
// with a polling master that moves bytes and forwards divider writes.
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                dividerStage1,
    uart_fifo_bridge_if.slave   host,
    uart_fifo_bridge_if.master  uart
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;
    localparam cnt_t FULL = cnt_t'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_DECIDE, S_CFG, S_RXRD, S_TXWR
    } state_t;

    state_t      state_q, state_d;
    ptr_t        tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    ptr_t        rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    cnt_t        tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [15:0] shadow_q, shadow_d;
    logic        cfg_pend_q, cfg_pend_d;
    logic        f_tx_q, f_tx_d, f_rx_q, f_rx_d;
    logic [7:0]  tx_mem_q [DEPTH];
    logic [7:0]  rx_mem_q [DEPTH];

    logic        sel_status, sel_counts, sel_data, sel_div;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0] status_w, counts_w, host_rdata;
    logic [3:0]  u_addr;
    logic        u_rd, u_wr;
    logic [31:0] u_wdata;
    logic        unused_ok;

    assign sel_status = host.address == 4'd0;
    assign sel_counts = host.address == 4'd4;
    assign sel_data   = host.address == 4'd8;
    assign sel_div    = host.address == 4'd12;

    assign tx_full  = tx_cnt_q == FULL;
    assign rx_full  = rx_cnt_q == FULL;
    assign tx_empty = tx_cnt_q == '0;
    assign rx_empty = rx_cnt_q == '0;

    assign tx_push = host.write && sel_data && !tx_full;
    assign tx_pop  = state_q == S_TXWR;
    assign rx_push = state_q == S_RXRD && !rx_full;
    assign rx_pop  = host.read && sel_data && !rx_empty;

    assign status_w = {27'd0, tx_ovf_q, rx_ovf_q, tx_empty,
                       !rx_empty, !tx_full};
    assign counts_w = (32'(rx_cnt_q) << 16) | 32'(tx_cnt_q);

    always_comb begin
        host_rdata = '0;
        if (host.read) begin
            unique case (1'b1)
                sel_status: host_rdata = status_w;
                sel_counts: host_rdata = counts_w;
                sel_data:   host_rdata = rx_empty ? 32'd0
                                       : {24'd0, rx_mem_q[rx_rp_q]};
                sel_div:    host_rdata = {16'd0, shadow_q};
                default:    host_rdata = '0;
            endcase
        end
    end

    assign host.readData    = host_rdata;
    assign host.waitrequest = 1'b0;

    always_comb begin
        state_d = state_q;
        u_addr  = 4'd0;
        u_rd    = 1'b0;
        u_wr    = 1'b0;
        u_wdata = '0;
        unique case (state_q)
            S_IDLE: state_d = S_POLL;
            S_POLL: begin
                u_rd    = 1'b1;
                state_d = S_DECIDE;
            end
            S_DECIDE: begin
                if (cfg_pend_q)              state_d = S_CFG;
                else if (f_rx_q)             state_d = S_RXRD;
                else if (f_tx_q && !tx_empty) state_d = S_TXWR;
                else                         state_d = S_POLL;
            end
            S_CFG: begin
                u_addr  = 4'd12;
                u_wr    = 1'b1;
                u_wdata = {16'd0, shadow_q};
                state_d = S_POLL;
            end
            S_RXRD: begin
                u_addr  = 4'd8;
                u_rd    = 1'b1;
                state_d = S_POLL;
            end
            S_TXWR: begin
                u_addr  = 4'd8;
                u_wr    = 1'b1;
                u_wdata = {24'd0, tx_mem_q[tx_rp_q]};
                state_d = S_POLL;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign uart.address   = u_addr;
    assign uart.read      = u_rd;
    assign uart.write     = u_wr;
    assign uart.writeData = u_wdata;

    always_comb begin
        tx_wp_d  = tx_wp_q + ptr_t'(tx_push);
        tx_rp_d  = tx_rp_q + ptr_t'(tx_pop);
        rx_wp_d  = rx_wp_q + ptr_t'(rx_push);
        rx_rp_d  = rx_rp_q + ptr_t'(rx_pop);
        tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
        rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
        f_tx_d   = state_q == S_POLL ? uart.readData[0] : f_tx_q;
        f_rx_d   = state_q == S_POLL ? uart.readData[1] : f_rx_q;
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        if (host.write && sel_status && host.writeData[4]) tx_ovf_d = 1'b0;
        if (host.write && sel_status && host.writeData[3]) rx_ovf_d = 1'b0;
        if (host.write && sel_data && tx_full)  tx_ovf_d = 1'b1;
        if (state_q == S_RXRD && rx_full)       rx_ovf_d = 1'b1;
        shadow_d   = shadow_q;
        cfg_pend_d = cfg_pend_q;
        if (state_q == S_CFG) cfg_pend_d = 1'b0;
        // A divider write racing the CFG access must still be forwarded.
        if (host.write && sel_div) begin
            shadow_d   = host.writeData[15:0];
            cfg_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge dividerStage1) begin
        if (!dividerStage1) begin
            state_q    <= S_IDLE;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            shadow_q   <= '0;
            cfg_pend_q <= 1'b0;
            f_tx_q     <= 1'b0;
            f_rx_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            shadow_q   <= shadow_d;
            cfg_pend_q <= cfg_pend_d;
            f_tx_q     <= f_tx_d;
            f_rx_q     <= f_rx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= host.writeData[7:0];
        if (rx_push) rx_mem_q[rx_wp_q] <= uart.readData[7:0];
    end

    assign unused_ok = &{1'b0, host.writeData[31:16], uart.readData[31:8]};
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Directed bench for uart_fifo_bridge with a small UART register model
// that logs every access seen on the master port.
module tb_uart_fifo_bridge;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_fifo_bridge_if host_bus ();
    uart_fifo_bridge_if uart_bus ();

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk          (clk),
        .dividerStage1(rst_n),
        .host         (host_bus.slave),
        .uart         (uart_bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } acc_t;

    acc_t       log_q[$];
    logic [7:0] rx_q[$];
    logic       tx_ready = 1'b0;
    logic       rx_avail = 1'b0;
    logic [7:0] rx_head  = 8'd0;
    int         both_cnt = 0;
    int         checks   = 0;
    int         passes   = 0;

    assign uart_bus.waitrequest = 1'b0;
    assign uart_bus.readData =
        (uart_bus.address == 4'd0) ? {30'd0, rx_avail, tx_ready} :
        (uart_bus.address == 4'd8) ? {24'd0, rx_head} : 32'd0;

    task automatic rx_upd;
        rx_avail = rx_q.size() != 0;
        rx_head  = rx_avail ? rx_q[0] : 8'd0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_q.push_back(b);
        rx_upd();
    endtask

    always @(posedge clk) begin
        if (uart_bus.read && uart_bus.address == 4'd8 && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            rx_upd();
        end
    end

    always @(negedge clk) begin
        if (uart_bus.read || uart_bus.write) begin
            if (uart_bus.read && uart_bus.write) both_cnt++;
            log_q.push_back('{wr: uart_bus.write, addr: uart_bus.address,
                data: uart_bus.write ? uart_bus.writeData : uart_bus.readData});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hwrite(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        host_bus.address   = a;
        host_bus.writeData = d;
        host_bus.write     = 1'b1;
        @(negedge clk);
        host_bus.write     = 1'b0;
    endtask

    task automatic hread(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        host_bus.address = a;
        host_bus.read    = 1'b1;
        #1 d = host_bus.readData;
        @(negedge clk);
        host_bus.read    = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        host_bus.address = 0; host_bus.read = 0;
        host_bus.write = 0; host_bus.writeData = 0;
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({uart_bus.read, uart_bus.write, host_bus.waitrequest} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000",
                {uart_bus.read, uart_bus.write, host_bus.waitrequest});
        else passes++;
        log_q.delete();
        rst_n = 1'b1;
        tick(6);
        checks++;
        if (log_q.size() == 0 || log_q[0].wr !== 1'b0 || log_q[0].addr !== 4'd0)
            $display("FAIL reset_first_poll: got n=%0d want read@0", log_q.size());
        else passes++;
        hread(4'd0, v);
        checks++;
        if (v !== 32'h5) $display("FAIL reset_status: got %h want 5", v);
        else passes++;
        hread(4'd4, v);
        checks++;
        if (v !== 32'h0) $display("FAIL reset_counts: got %h want 0", v);
        else passes++;
    endtask

    task automatic test_tx_drain;
        logic [31:0] v;
        logic [7:0]  exp [3];
        int          nw;
        exp = '{8'h41, 8'h42, 8'h43};
        tx_ready = 1'b1;
        tick(4);
        log_q.delete();
        hwrite(4'd8, 32'h41);
        hwrite(4'd8, 32'h42);
        hwrite(4'd8, 32'h43);
        tick(40);
        nw = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].wr) begin
                checks++;
                if (nw > 2 || log_q[i].addr !== 4'd8 ||
                    log_q[i].data !== {24'd0, exp[nw > 2 ? 0 : nw]})
                    $display("FAIL tx_write%0d: got %h@%0d", nw,
                        log_q[i].data, log_q[i].addr);
                else passes++;
                checks++;
                if (i == 0 || log_q[i-1].wr || log_q[i-1].addr !== 4'd0)
                    $display("FAIL tx_prepoll%0d: no poll before write", nw);
                else passes++;
                nw++;
            end
        end
        checks++;
        if (nw != 3) $display("FAIL tx_write_count: got %0d want 3", nw);
        else passes++;
        hread(4'd0, v);
        checks++;
        if (v !== 32'h5) $display("FAIL tx_status_empty: got %h want 5", v);
        else passes++;
    endtask

    task automatic test_tx_overflow;
        logic [31:0] v;
        int          nw;
        tx_ready = 1'b0;
        tick(4);
        for (int i = 0; i < 17; i++) hwrite(4'd8, 32'h60 + 32'(i));
        hread(4'd4, v);
        checks++;
        if (v !== 32'd16) $display("FAIL txovf_counts: got %h want 10", v);
        else passes++;
        hread(4'd0, v);
        checks++;
        if (v !== 32'h10) $display("FAIL txovf_status: got %h want 10", v);
        else passes++;
        hwrite(4'd0, 32'h10);
        hread(4'd0, v);
        checks++;
        if (v !== 32'h0) $display("FAIL txovf_clear: got %h want 0", v);
        else passes++;
        log_q.delete();
        tx_ready = 1'b1;
        tick(80);
        nw = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i].wr) begin
                checks++;
                if (log_q[i].data !== 32'h60 + 32'(nw))
                    $display("FAIL txovf_drain%0d: got %h want %h", nw,
                        log_q[i].data, 32'h60 + 32'(nw));
                else passes++;
                nw++;
            end
        end
        checks++;
        if (nw != 16) $display("FAIL txovf_drain_count: got %0d want 16", nw);
        else passes++;
        hread(4'd0, v);
        checks++;
        if (v !== 32'h5) $display("FAIL txovf_final_status: got %h want 5", v);
        else passes++;
    endtask

    task automatic test_rx_single;
        logic [31:0] v;
        int          nr;
        tx_ready = 1'b0;
        tick(4);
        log_q.delete();
        rx_push(8'h5A);
        tick(12);
        nr = 0;
        foreach (log_q[i]) if (!log_q[i].wr && log_q[i].addr == 4'd8) nr++;
        checks++;
        if (nr != 1) $display("FAIL rx_read_count: got %0d want 1", nr);
        else passes++;
        hread(4'd0, v);
        checks++;
        if (v !== 32'h7) $display("FAIL rx_status_ne: got %h want 7", v);
        else passes++;
        hread(4'd8, v);
        checks++;
        if (v !== 32'h5A) $display("FAIL rx_data: got %h want 5a", v);
        else passes++;
        hread(4'd0, v);
        checks++;
        if (v !== 32'h5) $display("FAIL rx_status_empty: got %h want 5", v);
        else passes++;
        hread(4'd8, v);
        checks++;
        if (v !== 32'h0) $display("FAIL rx_empty_read: got %h want 0", v);
        else passes++;
    endtask

    task automatic test_rx_overflow;
        logic [31:0] v;
        for (int i = 0; i < 16; i++) rx_push(8'(i));
        rx_push(8'hFF);
        tick(80);
        hread(4'd0, v);
        checks++;
        if (v !== 32'hF) $display("FAIL rxovf_status: got %h want f", v);
        else passes++;
        hread(4'd4, v);
        checks++;
        if (v !== 32'h0010_0000)
            $display("FAIL rxovf_counts: got %h want 00100000", v);
        else passes++;
        for (int i = 0; i < 16; i++) begin
            hread(4'd8, v);
            checks++;
            if (v !== 32'(i))
                $display("FAIL rxovf_data%0d: got %h want %h", i, v, 32'(i));
            else passes++;
        end
        hread(4'd8, v);
        checks++;
        if (v !== 32'h0) $display("FAIL rxovf_no_ff: got %h want 0", v);
        else passes++;
        hwrite(4'd0, 32'h08);
        hread(4'd0, v);
        checks++;
        if (v !== 32'h5) $display("FAIL rxovf_clear: got %h want 5", v);
        else passes++;
    endtask

    task automatic test_cfg_priority;
        logic [31:0] v;
        acc_t        np[$];
        acc_t        exp [3];
        exp = '{'{1'b1, 4'd12, 32'h1234},
                '{1'b0, 4'd8,  32'h33},
                '{1'b1, 4'd8,  32'h77}};
        tx_ready = 1'b0;
        tick(4);
        hwrite(4'd8, 32'h77);
        tick(4);
        @(negedge clk);
        log_q.delete();
        tx_ready = 1'b1;
        rx_push(8'h33);
        host_bus.address   = 4'd12;
        host_bus.writeData = 32'h1234;
        host_bus.write     = 1'b1;
        @(negedge clk);
        host_bus.write     = 1'b0;
        tick(20);
        foreach (log_q[i]) begin
            if (log_q[i].wr || log_q[i].addr != 4'd0) begin
                np.push_back(log_q[i]);
                checks++;
                if (i == 0 || log_q[i-1].wr || log_q[i-1].addr !== 4'd0)
                    $display("FAIL cfg_prepoll%0d: no poll before access", i);
                else passes++;
            end
        end
        checks++;
        if (np.size() != 3)
            $display("FAIL cfg_access_count: got %0d want 3", np.size());
        else passes++;
        for (int i = 0; i < 3 && i < np.size(); i++) begin
            checks++;
            if (np[i] !== exp[i])
                $display("FAIL cfg_seq%0d: got %h want %h", i, np[i], exp[i]);
            else passes++;
        end
        hread(4'd12, v);
        checks++;
        if (v !== 32'h1234) $display("FAIL cfg_readback: got %h want 1234", v);
        else passes++;
        hread(4'd8, v);
        checks++;
        if (v !== 32'h33) $display("FAIL cfg_rx_data: got %h want 33", v);
        else passes++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        tx_ready = 1'b0;
        tick(4);
        hwrite(4'd8, 32'hAA);
        hwrite(4'd8, 32'hBB);
        hwrite(4'd12, 32'h55);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({uart_bus.read, uart_bus.write} !== 2'b00)
            $display("FAIL midrst_strobes: got %b want 00",
                {uart_bus.read, uart_bus.write});
        else passes++;
        tick(2);
        rst_n = 1'b1;
        hread(4'd4, v);
        checks++;
        if (v !== 32'h0) $display("FAIL midrst_counts: got %h want 0", v);
        else passes++;
        hread(4'd12, v);
        checks++;
        if (v !== 32'h0) $display("FAIL midrst_shadow: got %h want 0", v);
        else passes++;
        checks++;
        if (both_cnt != 0) $display("FAIL rd_wr_overlap: got %0d want 0", both_cnt);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_tx_drain();
        test_tx_overflow();
        test_rx_single();
        test_rx_overflow();
        test_cfg_priority();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Sits between the system bus and the SoC UART register slave. The UART itself has no I/O FIFOs.
- Gives the host a buffered TX FIFO and RX FIFO.
- An internal master FSM polls the UART flags register, drains the TX FIFO into the UART, and moves received bytes into the RX FIFO so software no longer has to read fast.
- Clock divider writes are forwarded through the same master port.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (default 16 entries per FIFO).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- dividerStage1  input  1  reset; asynchronous, active-low.
- address  input  4  host register byte address.
- read  input  1  host read strobe.
- readData  output  32  host read data; combinational, 0 when read=0.
- write  input  1  host write strobe.
- writeData  input  32  host write data.
- waitrequest  output  1  tied 0.
- uart_address  output  4  UART slave address.
- uart_read  output  1  UART read strobe.
- uart_readData  input  32  UART read data; combinational, valid in the same cycle as uart_read.
- uart_write  output  1  UART write strobe.
- uart_writeData  output  32  UART write data.

Behaviour:
- Host register map:
  - 0 STATUS:
    - bit0 tx_not_full
    - bit1 rx_not_empty
    - bit2 tx_empty
    - bit3 rx_overflow (sticky)
    - bit4 tx_overflow (sticky)
    - bits 31:5 = 0
    - Writing 1 to bit3 or bit4 clears that bit.
  - 4 COUNTS: bits[DEPTH_LOG2:0] = tx count; bits[16+DEPTH_LOG2:16] = rx count.
  - 8 DATA:
    - Write pushes writeData[7:0] to the TX FIFO.
    - Read returns the RX FIFO head in bits [7:0] and pops it on that edge.
  - 12 DIVIDER: write stores writeData[15:0] in a shadow register and sets cfg_pending. Read returns the shadow.
  - Any other address reads 0; writes are ignored.
- FIFOs:
  - Circular buffers with DEPTH_LOG2-bit pointers that wrap naturally.
  - Counts are DEPTH_LOG2+1 bits wide; full means count == 2^DEPTH_LOG2.
- Full/empty rules:
  - Push to a full TX FIFO is dropped and sets tx_overflow. The full test uses the pre-edge count, even if a pop happens in the same cycle.
  - Read of DATA when the RX FIFO is empty returns 0, with no pop and no flag change.
  - A simultaneous push and pop on the same FIFO both take effect; the count is unchanged.
- Master FSM. Each UART access is exactly one cycle, and uart_read and uart_write are never both high.
  - IDLE -> POLL unconditionally.
  - POLL:
    - Drive uart_address=0, uart_read=1.
    - Latch flags: f_tx = uart_readData[0], f_rx = uart_readData[1].
    - Go to DECIDE.
  - DECIDE (no UART access). Priority order:
    1. cfg_pending -> CFG.
    2. f_rx -> RXRD.
    3. f_tx and TX not empty -> TXWR.
    4. Otherwise -> POLL.
  - CFG: uart_address=12, uart_write=1, uart_writeData = zero-extended shadow; clear cfg_pending; -> POLL. A host DIVIDER write in this same cycle updates the shadow and leaves cfg_pending set.
  - RXRD:
    - uart_address=8, uart_read=1.
    - Push uart_readData[7:0] to the RX FIFO if not full.
    - If full, discard the byte and set rx_overflow. The read is always performed so the UART's ready flag clears.
    - -> POLL.
  - TXWR: uart_address=8, uart_write=1, uart_writeData = zero-extended TX head; pop the TX FIFO; -> POLL.
  - Every UART access is followed by a fresh POLL before the next access, so stale flags are never reused.
  - Host-side pushes and pops have no effect on FSM sequencing.
- Reset (dividerStage1 low, asynchronous), all cleared:
  - Pointers, counts, sticky flags, shadow, cfg_pending, f_tx, f_rx = 0.
  - FSM = IDLE.
  - uart_read, uart_write = 0; uart_address, uart_writeData = 0.
- Reset mid-operation aborts any access in flight and discards both FIFOs' contents.
- When idle, with no data and no pending config, the bridge repeats POLL, DECIDE indefinitely.

Test Plan:
- Reset: hold dividerStage1 low, release. Required: STATUS = 0x5 (tx_not_full, tx_empty), COUNTS = 0, uart_write = 0, and the first UART access is POLL at address 0.
- Host writes 0x41, 0x42, 0x43 to address 8; UART model reports flags = 0x1. Required: exactly three uart_write cycles at address 8 with data 0x41, 0x42, 0x43 in order, each preceded by a POLL; final STATUS bit2 = 1.
- Write 17 bytes with the model reporting flags = 0x0. Required: COUNTS tx = 16, STATUS bit4 = 1, bit0 = 0. Then write 0x10 to address 0. Required: bit4 = 0.
- Model reports flags = 0x2 with data 0x5A, then flags = 0x0. Required: one uart_read at address 8; host read of address 8 returns 0x5A; rx_not_empty then returns to 0. A further DATA read returns 0.
- Fill the RX FIFO with 16 bytes (0x00..0x0F), then one more byte 0xFF arrives. Required: rx_overflow = 1, and host reads return 0x00..0x0F with no 0xFF.
- Host writes 0x1234 to address 12 while TX data is pending and flags = 0x3. Required: the next access after DECIDE is uart_write at address 12 with data 0x1234, then RXRD, then TXWR. Address 12 reads back 0x1234.
